// File: rtl/mem_bus_pkg.sv
// Shared definitions for the single-port memory bus: default widths and the
// initiator FSM state type, used by mem_master, its interface and the memory block.
package mem_bus_pkg;

    localparam int MEM_DATA_WIDTH = 8;
    localparam int MEM_ADDR_WIDTH = 5;
    localparam int MEM_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } mm_state_t;

endpackage

// File: rtl/mem_master_if.sv
// Request/response handshake plus memory-bus signals of mem_master.
// master = mem_master's view; slave = the sequencer/memory side.
interface mem_master_if #(
    parameter int DATA_WIDTH = mem_bus_pkg::MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_bus_pkg::MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = mem_bus_pkg::MEM_LEN_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  busy;
    logic                  done;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid, req_wr, req_addr, req_len, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, busy, done,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_len, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, busy, done,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_master.sv
// Sole initiator of the single-port memory bus: single/burst fill and read requests,
// one beat per cycle. Define MEM_MASTER_STATS_EN to add rd_beats/wr_beats counters.
module mem_master
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = MEM_LEN_WIDTH
) (
    input  logic         clk_,
    input  logic         rst_,
    mem_master_if.master bus
`ifdef MEM_MASTER_STATS_EN
    ,
    output logic [15:0]  rd_beats,
    output logic [15:0]  wr_beats
`endif
);

    mm_state_t             state;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  req_ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rsp_valid_q;
    logic                  mem_rd_q;
    logic                  mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    // NOTE: reset is synchronous, so rst_ is only tested inside the clocked block
    // and is deliberately absent from the sensitivity list.
    always_ff @(posedge clk_) begin
        if (!rst_) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // e.g. rsp_valid follows the read strobe of the previous cycle.
            done_q      <= 1'b0;
            rsp_valid_q <= mem_rd_q;

            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        beat_cnt    <= bus.req_len;
                        mem_addr_q  <= bus.req_addr;
                        if (bus.req_wr) begin
                            state       <= WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= bus.req_wdata;
                        end else begin
                            state    <= READ;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (beat_cnt == '0) begin
                        state       <= IDLE;
                        mem_wr_q    <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end else begin
                        beat_cnt   <= beat_cnt - LEN_WIDTH'(1);
                        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                    end
                end

                READ: begin
                    // done lands on the cycle carrying the last response
                    if (beat_cnt == '0) begin
                        state    <= DRAIN;
                        mem_rd_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        beat_cnt   <= beat_cnt - LEN_WIDTH'(1);
                        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                    end
                end

                DRAIN: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = bus.mem_rdata;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef MEM_MASTER_STATS_EN
    // A beat counts as completed at the edge that ends its strobe cycle.
    always_ff @(posedge clk_) begin
        if (!rst_) begin
            rd_beats <= '0;
            wr_beats <= '0;
        end else begin
            if (mem_rd_q && (rd_beats != 16'hFFFF)) rd_beats <= rd_beats + 16'd1;
            if (mem_wr_q && (wr_beats != 16'hFFFF)) wr_beats <= wr_beats + 16'd1;
        end
    end
`endif

endmodule
